// File: rtl/para_pkg.sv
// Shared constants, frame layout and types for the host parameter command decoder.
package para_pkg;

    localparam logic [7:0]  HDR0          = 8'hEB;
    localparam logic [7:0]  HDR1          = 8'h90;
    localparam int unsigned PAYLOAD_BYTES = 21;
    localparam int unsigned PAYLOAD_BITS  = 8 * PAYLOAD_BYTES;

    localparam int unsigned CTRL_RESET      = 0;
    localparam int unsigned CTRL_BEGIN_SEND = 1;
    localparam int unsigned CTRL_BEGIN_SET  = 2;
    localparam int unsigned CTRL_OUT_EN     = 3;
    localparam int unsigned CTRL_SYN_EN     = 4;
    localparam int unsigned CTRL_SCRAMBLE   = 5;

    // Byte offsets of each field within the payload (first payload byte = 0).
    localparam int unsigned OFF_DATA_LEN  = 0;
    localparam int unsigned OFF_BLANK_LEN = 4;
    localparam int unsigned OFF_MODE      = 8;
    localparam int unsigned OFF_DATA_MODE = 9;
    localparam int unsigned OFF_FLAG_MODE = 10;
    localparam int unsigned OFF_CTRL      = 11;
    localparam int unsigned OFF_PKT_HEAD  = 12;
    localparam int unsigned OFF_FLAG_SET  = 16;
    localparam int unsigned OFF_LEN_SET   = 18;

    typedef enum logic [2:0] {
        ST_H0,
        ST_H1,
        ST_CHAN,
        ST_PAY,
        ST_CSUM,
        ST_APPLY
    } state_t;

    typedef struct packed {
        logic [31:0] data_length;
        logic [31:0] blank_length;
        logic [7:0]  mode;
        logic [7:0]  data_mode;
        logic [7:0]  flag_mode;
        logic [5:0]  ctrl;
        logic [31:0] packet_head;
        logic [15:0] flag_set;
        logic [23:0] length_set;
    } fields_t;

endpackage

// File: rtl/para_cmd_decoder.sv
// Parses EB 90 CH <21 payload> CS frames and drives the parameter bus to one
// channel for APPLY_CYCLES clocks per good frame.
module para_cmd_decoder
    import para_pkg::*;
#(
    parameter logic [7:0]  CH_IDLE      = 8'hFF,
    parameter int unsigned APPLY_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  channel,
    output logic        reset,
    output logic        begin_send,
    output logic        begin_set,
    output logic        out_en,
    output logic        syn_en,
    output logic        scramble,
    output logic [31:0] data_length,
    output logic [31:0] blank_length,
    output logic [31:0] packet_head,
    output logic [7:0]  mode,
    output logic [7:0]  data_mode,
    output logic [7:0]  flag_mode,
    output logic [15:0] flag_set,
    output logic [23:0] length_set,
    output logic        busy,
    output logic        cmd_done,
    output logic        cmd_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    state_t                  state_q, state_d;
    logic [7:0]              ch_q, ch_d;
    logic [7:0]              sum_q, sum_d;
    logic [7:0]              cs_q, cs_d;
    logic                    cs_vld_q, cs_vld_d;
    logic [4:0]              idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] shadow_q, shadow_d;
    logic [TO_W-1:0]         to_q, to_d;
    logic [3:0]              apply_q, apply_d;
    logic [7:0]              channel_q, channel_d;
    fields_t                 fields_q, fields_d;
    fields_t                 shadow_fields;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    timed_out;

    always_comb begin
        shadow_fields.data_length  = shadow_q[PAYLOAD_BITS-1-8*OFF_DATA_LEN  -: 32];
        shadow_fields.blank_length = shadow_q[PAYLOAD_BITS-1-8*OFF_BLANK_LEN -: 32];
        shadow_fields.mode         = shadow_q[PAYLOAD_BITS-1-8*OFF_MODE      -: 8];
        shadow_fields.data_mode    = shadow_q[PAYLOAD_BITS-1-8*OFF_DATA_MODE -: 8];
        shadow_fields.flag_mode    = shadow_q[PAYLOAD_BITS-1-8*OFF_FLAG_MODE -: 8];
        shadow_fields.ctrl         = shadow_q[PAYLOAD_BITS-1-8*OFF_CTRL-2    -: 6];
        shadow_fields.packet_head  = shadow_q[PAYLOAD_BITS-1-8*OFF_PKT_HEAD  -: 32];
        shadow_fields.flag_set     = shadow_q[PAYLOAD_BITS-1-8*OFF_FLAG_SET  -: 16];
        shadow_fields.length_set   = shadow_q[PAYLOAD_BITS-1-8*OFF_LEN_SET   -: 24];
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        sum_d     = sum_q;
        cs_d      = cs_q;
        cs_vld_d  = cs_vld_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        apply_d   = apply_q;
        channel_d = channel_q;
        fields_d  = fields_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        to_d      = '0;
        timed_out = 1'b0;

        // Idle counter runs only mid-frame; any accepted byte clears it.
        if (state_q inside {ST_H1, ST_CHAN, ST_PAY, ST_CSUM} && !rx_valid && !cs_vld_q) begin
            if (to_q == TO_W'(TIMEOUT - 1)) begin
                timed_out = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end

        case (state_q)
            ST_H0: begin
                if (rx_valid && rx_data == HDR0) state_d = ST_H1;
            end
            ST_H1: begin
                if (rx_valid) begin
                    if (rx_data == HDR1)      state_d = ST_CHAN;
                    else if (rx_data != HDR0) state_d = ST_H0;
                end
            end
            ST_CHAN: begin
                if (rx_valid) begin
                    ch_d    = rx_data;
                    sum_d   = rx_data;
                    idx_d   = '0;
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                if (rx_valid) begin
                    shadow_d = {shadow_q[PAYLOAD_BITS-9:0], rx_data};
                    sum_d    = sum_q + rx_data;
                    idx_d    = idx_q + 5'd1;
                    if (idx_q == 5'(PAYLOAD_BYTES - 1)) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                // CS byte is registered first and judged one cycle later.
                if (cs_vld_q) begin
                    cs_vld_d = 1'b0;
                    if (cs_q == sum_q && ch_q != CH_IDLE) begin
                        state_d   = ST_APPLY;
                        apply_d   = '0;
                        channel_d = ch_q;
                        fields_d  = shadow_fields;
                        done_d    = 1'b1;
                    end else begin
                        state_d = ST_H0;
                        err_d   = 1'b1;
                    end
                end else if (rx_valid) begin
                    cs_d     = rx_data;
                    cs_vld_d = 1'b1;
                end
            end
            ST_APPLY: begin
                if (apply_q == 4'(APPLY_CYCLES - 1)) begin
                    state_d   = ST_H0;
                    channel_d = CH_IDLE;
                end else begin
                    apply_d = apply_q + 4'd1;
                end
            end
            default: state_d = ST_H0;
        endcase

        if (timed_out) begin
            state_d = ST_H0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_H0;
            ch_q      <= '0;
            sum_q     <= '0;
            cs_q      <= '0;
            cs_vld_q  <= 1'b0;
            idx_q     <= '0;
            shadow_q  <= '0;
            to_q      <= '0;
            apply_q   <= '0;
            channel_q <= CH_IDLE;
            fields_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            sum_q     <= sum_d;
            cs_q      <= cs_d;
            cs_vld_q  <= cs_vld_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            to_q      <= to_d;
            apply_q   <= apply_d;
            channel_q <= channel_d;
            fields_q  <= fields_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign channel      = channel_q;
    assign reset        = fields_q.ctrl[CTRL_RESET];
    assign begin_send   = fields_q.ctrl[CTRL_BEGIN_SEND];
    assign begin_set    = fields_q.ctrl[CTRL_BEGIN_SET];
    assign out_en       = fields_q.ctrl[CTRL_OUT_EN];
    assign syn_en       = fields_q.ctrl[CTRL_SYN_EN];
    assign scramble     = fields_q.ctrl[CTRL_SCRAMBLE];
    assign data_length  = fields_q.data_length;
    assign blank_length = fields_q.blank_length;
    assign packet_head  = fields_q.packet_head;
    assign mode         = fields_q.mode;
    assign data_mode    = fields_q.data_mode;
    assign flag_mode    = fields_q.flag_mode;
    assign flag_set     = fields_q.flag_set;
    assign length_set   = fields_q.length_set;
    assign busy         = (state_q != ST_H0);
    assign cmd_done     = done_q;
    assign cmd_err      = err_q;

endmodule

// File: doc/para_cmd_decoder.md
# para_cmd_decoder

Host-side parameter command decoder; the transmit end of the per-channel parameter bus. It parses a framed byte stream from the host UART/USB receiver and validates the header, channel and checksum. On a good frame it drives the `channel` select together with the full parameter field set for `APPLY_CYCLES` clocks, so that only the matching per-channel parameter latch captures it. It sits between the host link receiver and all channel parameter latches.

## Interface
- `CH_IDLE`, 8'hFF, channel value driven when no update is active; no sink uses it.
- `APPLY_CYCLES`, 2, cycles `channel` is held at the target value (1..15).
- `TIMEOUT`, 100000, max idle cycles between bytes inside a frame (≥2).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle qualifier for `rx_data`; no backpressure.
- `channel` out 8: target channel select.
- `reset`, `begin_send`, `begin_set`, `out_en`, `syn_en`, `scramble` out 1 each: control bits.
- `data_length`, `blank_length` out 32; `packet_head` out 32.
- `mode`, `data_mode`, `flag_mode` out 8.
- `flag_set` out 16; `length_set` out 24.
- `busy` out 1: high from the first header byte accepted to the end of APPLY.
- `cmd_done` out 1: one-cycle pulse, good frame applied.
- `cmd_err` out 1: one-cycle pulse, frame rejected (checksum, reserved channel, timeout).

## Operation
- Frame is 25 bytes: 8'hEB, 8'h90, CH, 21 payload bytes, CS.
- Payload order, multi-byte fields big-endian: data_length[4], blank_length[4], mode, data_mode, flag_mode, ctrl, packet_head[4], flag_set[2], length_set[3].
- ctrl bits: [0] reset, [1] begin_send, [2] begin_set, [3] out_en, [4] syn_en, [5] scramble, [7:6] ignored.
- CS = (CH + sum of 21 payload bytes) mod 256. Headers are excluded.
- FSM states and transitions:
  - H0: byte EB → H1.
  - H1: 90 → CHAN; EB → stay in H1; other → H0.
  - CHAN: store CH, seed sum → PAY.
  - PAY: 5-bit index 0..20, shift bytes into the shadow; at index 20 → CSUM.
  - CSUM: match and CH≠CH_IDLE → APPLY; otherwise `cmd_err` → H0.
  - APPLY: hold `channel` for APPLY_CYCLES, then → H0.
- Shadow registers are internal. Field outputs load from the shadow only on entry to APPLY, so a rejected frame never alters the outputs.
- Field outputs hold their values between frames. `channel`=CH_IDLE outside APPLY.
- Timeout: in H1/CHAN/PAY/CSUM, a counter clears on each `rx_valid`. When it reaches TIMEOUT, pulse `cmd_err` and go to H0; the partial frame is discarded.
- Bytes arriving during APPLY are dropped; the host spaces frames accordingly.

## Timing
- Reset values: `channel`=CH_IDLE; all fields 0; `busy`, `cmd_done`, `cmd_err`=0; FSM=H0; counters 0.
- Reset mid-frame aborts with no pulse and no output change except the reset values.
- CS byte accepted at edge N:
  - Fields and `channel` become valid after edge N+1 and are held through edge N+APPLY_CYCLES.
  - `cmd_done` is high in the first APPLY cycle.
  - `channel` returns to CH_IDLE and `busy` falls after edge N+APPLY_CYCLES+1.
- Fields change in the same cycle `channel` goes active. The latch on the matching channel sees consistent data on every cycle it matches.
- Bad CS accepted at edge N: `cmd_err` high after edge N+1 for one cycle.
- Back-to-back `rx_valid` every cycle must be handled.

## Structure
- Shared package `para_pkg`:
  - Header constants `HDR0`/`HDR1`.
  - `PAYLOAD_BYTES`=21.
  - ctrl bit index constants.
  - FSM state enum.
  - Payload field byte offsets.
- No sub-module. The timeout counter is inline.

## Test plan
- Good frame CH=8'h03, data_length=32'h0000_1000, ctrl=8'h09, rest 0 → `channel`=3 for 2 cycles, `data_length`=4096, `reset`=1, `out_en`=1, one `cmd_done`, then `channel`=FF.
- Same frame with CS+1 → one `cmd_err`; all outputs unchanged; `channel` stays FF.
- Stream EB EB 90 03 … valid → frame accepted (repeated-EB resync).
- Stop after 10 payload bytes for TIMEOUT cycles → `cmd_err` at exactly TIMEOUT; the next full frame decodes correctly.
- CH=8'hFF with correct CS → `cmd_err`; no apply.
- Assert `rst` at payload byte 12 → reset values next cycle; a subsequent full frame decodes correctly.
